// File: rtl/aes_kexp_pkg.sv
// Shared types, S-box table and byte/word helpers for the AES key-schedule engine.
package aes_kexp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } kexp_state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam int         MAX_NW    = 60;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_subword
  import aes_kexp_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = {SBOX[din[31:24]], SBOX[din[23:16]], SBOX[din[15:8]], SBOX[din[7:0]]};

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128/192/256 key schedule, one word per cycle (NW-NK cycles start->done),
// with a registered round-key read port. KEXP_ZEROIZE_EN adds a zeroize input that wipes storage.
module aes_key_expand_seq
  import aes_kexp_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
`ifdef KEXP_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic [255:0] key,
  output logic         busy,
  output logic         done,
  output logic         rk_valid,
  input  logic [3:0]   rk_rd_idx,
  output logic [127:0] rk_rd_data
);

  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [5:0] NK_W    = 6'(NK);
  localparam logic [5:0] LAST_W  = 6'(NW - 1);
  localparam logic [2:0] KM_LAST = 3'(NK - 1);
  localparam logic [3:0] NR_W    = 4'(NR);

  if (!(NK == 4 || NK == 6 || NK == 8) || NW > MAX_NW) begin : g_bad_nk
    $error("aes_key_expand_seq: NK must be 4, 6 or 8");
  end

  kexp_state_t state;
  logic [5:0]  i;
  logic [2:0]  kmod;
  logic [7:0]  rcon;
  logic [31:0] w [NW];

  logic        zero_req;
  logic        load;
  logic [31:0] prev_w, back_w, sub_in, sub_out, temp, new_w;
  logic [5:0]  rd_base;
  logic        unused_key_bits;

`ifdef KEXP_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  // Upper key words only are consumed for NK < 8.
  assign unused_key_bits = ^key;

  assign load = start && (state != EXPAND) && !zero_req;

  always_comb begin
    prev_w = w[i - 6'd1];
    back_w = w[i - NK_W];
    sub_in = (kmod == 3'd0) ? rot_word(prev_w) : prev_w;
    temp   = prev_w;
    if (kmod == 3'd0)
      temp = sub_out ^ {rcon, 24'h0};
    else if (NK == 8 && kmod == 3'd4)
      temp = sub_out;
  end

  assign new_w = back_w ^ temp;

  aes_subword u_subword (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rk_valid <= 1'b0;
      i        <= '0;
      kmod     <= '0;
      rcon     <= RCON_INIT;
    end else begin
      done <= 1'b0;
      if (zero_req) begin
        state    <= IDLE;
        busy     <= 1'b0;
        rk_valid <= 1'b0;
      end else begin
        case (state)
          IDLE, READY: begin
            if (start) begin
              state    <= EXPAND;
              busy     <= 1'b1;
              rk_valid <= 1'b0;
              i        <= NK_W;
              kmod     <= '0;
              rcon     <= RCON_INIT;
            end
          end
          EXPAND: begin
            i    <= i + 6'd1;
            kmod <= (kmod == KM_LAST) ? 3'd0 : kmod + 3'd1;
            if (kmod == 3'd0)
              rcon <= xtime(rcon);
            if (i == LAST_W) begin
              state    <= READY;
              busy     <= 1'b0;
              done     <= 1'b1;
              rk_valid <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef KEXP_ZEROIZE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NW; k++) w[k] <= '0;
    end else if (zero_req) begin
      for (int k = 0; k < NW; k++) w[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < NK; k++) w[k] <= key[255 - 32*k -: 32];
    end else if (state == EXPAND) begin
      w[i] <= new_w;
    end
  end
`else
  // Storage is deliberately not reset; rk_valid qualifies its contents.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < NK; k++) w[k] <= key[255 - 32*k -: 32];
    end else if (state == EXPAND) begin
      w[i] <= new_w;
    end
  end
`endif

  assign rd_base = {rk_rd_idx, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rk_rd_data <= '0;
    else if (zero_req || rk_rd_idx > NR_W)
      rk_rd_data <= '0;
    else
      rk_rd_data <= {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
  end

endmodule
